conv3_window_ctrl: RTL

Frame sequencer for the 3x3 sliding-window line-buffer datapath. It accepts a raster pixel stream under a valid/ready handshake and drives the line buffer's shift enable. It tracks row and column of every accepted pixel and flags the cycles on which the 3x3 window outputs hold a complete in-image window. Downstream backpressure freezes the shift chain, and a one-cycle done pulse closes each frame. It sits between the pixel source and the convolution MAC, alongside the window line buffer.

---
 rtl/conv3_window_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/conv3_window_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : conv3_window_ctrl                                             |
// | Function : Frame sequencer for the 3x3 sliding-window line buffer.       |
// |            Accepts a raster pixel stream, drives the line-buffer shift   |
// |            enable, tracks pixel row/column, qualifies complete in-image |
// |            windows, honours downstream backpressure and pulses          |
// |            Frame_Done at the end of each frame.                          |
// | Options  : WIN_CTRL_ERR_CHK_EN adds a sticky Err output flagging         |
// |            upstream overrun and Start during an active frame.            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module conv3_window_ctrl #(
   parameter int IMG_Width  = 5,
   parameter int IMG_Height = 5,
   parameter int CntWidth   = 8
) (
   input  logic                CLK,
   input  logic                CLR,
   input  logic                Start,
   input  logic                Pix_Valid,
   output logic                Pix_Ready,
   output logic                LB_WE,
   input  logic                Out_Ready,
   output logic                Win_Valid,
   output logic [CntWidth-1:0] Col,
   output logic [CntWidth-1:0] Row,
   output logic                Busy,
   output logic                Frame_Done
`ifdef WIN_CTRL_ERR_CHK_EN
   ,
   output logic                Err
`endif
);

   localparam logic [CntWidth-1:0] c_LAST_COL = CntWidth'(IMG_Width - 1);
   localparam logic [CntWidth-1:0] c_LAST_ROW = CntWidth'(IMG_Height - 1);
   localparam logic [CntWidth-1:0] c_WIN_MIN  = CntWidth'(2);
   localparam logic [CntWidth-1:0] c_ONE      = CntWidth'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CntWidth-1:0] col_cnt_q, col_cnt_d;
   logic [CntWidth-1:0] row_cnt_q, row_cnt_d;
   logic                win_valid_q, win_valid_d;
   logic [CntWidth-1:0] win_col_q, win_col_d;
   logic [CntWidth-1:0] win_row_q, win_row_d;
   logic                frame_done;

   logic w_pix_ready;
   logic w_accept;
   logic w_last_pix;
   logic w_qualify;

   // A pending window that is not being consumed freezes the shift chain.
   assign w_pix_ready = (state_q == S_RUN) && (!win_valid_q || Out_Ready);
   assign w_accept    = Pix_Valid && w_pix_ready;
   assign w_last_pix  = (col_cnt_q == c_LAST_COL) && (row_cnt_q == c_LAST_ROW);
   // Columns 0/1 hold row-wrap windows and rows 0/1 top-border windows.
   assign w_qualify   = w_accept && (row_cnt_q >= c_WIN_MIN) && (col_cnt_q >= c_WIN_MIN);

   // Next-state and frame-done decode.
   always_comb begin
      state_d    = state_q;
      frame_done = 1'b0;
      case (state_q)
         S_IDLE:  if (Start) state_d = S_RUN;
         S_RUN:   if (w_accept && w_last_pix) state_d = S_DRAIN;
         S_DRAIN: if (!win_valid_q || Out_Ready) state_d = S_DONE;
         S_DONE: begin
            frame_done = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Raster position of the next pixel to be accepted.
   always_comb begin
      col_cnt_d = col_cnt_q;
      row_cnt_d = row_cnt_q;
      if (state_q == S_IDLE && Start) begin
         col_cnt_d = '0;
         row_cnt_d = '0;
      end else if (w_accept) begin
         if (col_cnt_q == c_LAST_COL) begin
            col_cnt_d = '0;
            row_cnt_d = (row_cnt_q == c_LAST_ROW) ? '0 : row_cnt_q + c_ONE;
         end else begin
            col_cnt_d = col_cnt_q + c_ONE;
         end
      end
   end

   // Window qualifier: a new qualifying pixel wins over consumption.
   always_comb begin
      win_valid_d = win_valid_q;
      win_col_d   = win_col_q;
      win_row_d   = win_row_q;
      if (w_qualify) begin
         win_valid_d = 1'b1;
         win_col_d   = col_cnt_q;
         win_row_d   = row_cnt_q;
      end else if (Out_Ready) begin
         win_valid_d = 1'b0;
      end
   end

   // State, counter and window registers.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_q     <= S_IDLE;
         col_cnt_q   <= '0;
         row_cnt_q   <= '0;
         win_valid_q <= 1'b0;
         win_col_q   <= '0;
         win_row_q   <= '0;
      end else begin
         state_q     <= state_d;
         col_cnt_q   <= col_cnt_d;
         row_cnt_q   <= row_cnt_d;
         win_valid_q <= win_valid_d;
         win_col_q   <= win_col_d;
         win_row_q   <= win_row_d;
      end
   end

`ifdef WIN_CTRL_ERR_CHK_EN
   logic err_q, err_d;
   logic w_err_evt;

   assign w_err_evt = (Pix_Valid && (state_q == S_DRAIN || state_q == S_DONE)) ||
                      (Start && state_q == S_RUN);
   assign err_d     = err_q || w_err_evt;

   // Sticky protocol-error flag, cleared only by CLR.
   always_ff @(posedge CLK) begin
      if (CLR) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign Err = err_q;
`endif

   assign Pix_Ready  = w_pix_ready;
   assign LB_WE      = w_accept;
   assign Win_Valid  = win_valid_q;
   assign Col        = win_col_q;
   assign Row        = win_row_q;
   assign Busy       = (state_q != S_IDLE);
   assign Frame_Done = frame_done;

endmodule
`default_nettype wire
